mem_wb_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage with a valid/ready handshake, 2-entry skid buffer and synchronous flush.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/load_extract.sv | 29 ++
 rtl/mem_wb_stage.sv | 112 +++++++++++
 tb/tb_mem_wb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the MEM->WB stage
package riscv_pkg;

  localparam int ENTRY_XLEN = 32;
  localparam int ENTRY_RA_W = 5;
  localparam int ENTRY_SB_W = 8;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] load_data;
    logic [ENTRY_XLEN-1:0] alu_result;
    logic [ENTRY_XLEN-1:0] pc_plus4;
    logic [ENTRY_RA_W-1:0] rd;
    logic                  reg_write;
    wb_sel_e               wb_sel;
    logic [2:0]            funct3;
    logic [ENTRY_SB_W-1:0] sb;
  } mem_wb_entry_t;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational load byte/half extraction and extension
module load_extract
  import riscv_pkg::*;
#(
  parameter int XLEN = ENTRY_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    // off[0] is ignored for halves; misalignment is not trapped here
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB register stage with skid buffer, flush and write-back select
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = ENTRY_XLEN,
  parameter int REG_ADDR_W = ENTRY_RA_W,
  parameter int SB_W       = ENTRY_SB_W,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_load_data,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [SB_W-1:0]       in_sb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_wb_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic [SB_W-1:0]       out_sb
);

  mem_wb_entry_t   main_q, main_d, skid_q, skid_d, in_entry;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, drain;
  logic [XLEN-1:0] load_val, wb_val;

  // With the skid buffer, in_ready depends only on registered state (no path from out_ready)
  assign in_ready = resetn & ((SKID != 0) ? ~skid_valid_q : (out_ready | ~main_valid_q));
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    in_entry = '{
      load_data:  in_load_data,
      alu_result: in_alu_result,
      pc_plus4:   in_pc_plus4,
      rd:         in_rd,
      reg_write:  in_reg_write,
      wb_sel:     wb_sel_e'(in_wb_sel),
      funct3:     in_funct3,
      sb:         in_sb
    };
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if ((SKID != 0) && drain && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (accept && (SKID != 0)) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .word   (main_q.load_data),
    .off    (main_q.alu_result[1:0]),
    .funct3 (main_q.funct3),
    .result (load_val)
  );

  always_comb begin
    case (main_q.wb_sel)
      WB_LOAD: wb_val = load_val;
      WB_PC4:  wb_val = main_q.pc_plus4;
      default: wb_val = main_q.alu_result;
    endcase
  end

  // Stale fields survive a flush, so every output is gated by the head valid bit
  assign out_valid     = main_valid_q;
  assign out_wb_data   = main_valid_q ? wb_val : '0;
  assign out_rd        = main_valid_q ? main_q.rd : '0;
  assign out_sb        = main_valid_q ? main_q.sb : '0;
  assign out_reg_write = main_valid_q & main_q.reg_write & (|main_q.rd);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a 2-deep FIFO model
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready;
  logic [31:0] in_load_data, in_alu_result, in_pc_plus4;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [7:0]  in_sb;
  logic        out_valid, out_ready, out_reg_write;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic [7:0]  out_sb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic [7:0]  sb;
  } exp_t;
  exp_t mq[$];

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .SB_W(8), .SKID(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load_data(in_load_data), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_data(out_wb_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_sb(out_sb)
  );

  function automatic logic [31:0] ref_wb(input logic [31:0] w, input logic [31:0] a,
                                         input logic [31:0] p, input logic [1:0] sel,
                                         input logic [2:0] f3);
    logic [31:0] off, b, h, ld;
    off = a % 4;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    ld = (b >= 128) ? 32'hFFFFFF00 + b : b;
      3'd1:    ld = (h >= 32768) ? 32'hFFFF0000 + h : h;
      3'd4:    ld = b;
      3'd5:    ld = h;
      default: ld = w;
    endcase
    if (sel == 2'd1)      return ld;
    else if (sel == 2'd2) return p;
    else                  return a;
  endfunction

  task automatic set_beat(input logic v, input logic [31:0] ld, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                          input logic [1:0] sel, input logic [2:0] f3, input logic [7:0] sb);
    in_valid = v; in_load_data = ld; in_alu_result = alu; in_pc_plus4 = pc4;
    in_rd = rd; in_reg_write = rw; in_wb_sel = sel; in_funct3 = f3; in_sb = sb;
  endtask

  // One clock: model decides accept/drain from pre-edge state, then updates after the edge
  task automatic tick();
    bit   acc, drn;
    exp_t e;
    acc = in_valid && resetn && (mq.size() < 2);
    drn = resetn && (mq.size() > 0) && out_ready;
    e.wb = ref_wb(in_load_data, in_alu_result, in_pc_plus4, in_wb_sel, in_funct3);
    e.rd = in_rd; e.rw = in_reg_write; e.sb = in_sb;
    @(posedge clk);
    if (!resetn || flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb: got %h expected 0", out_wb_data); end
    checks++; if (out_rd !== 5'd0 || out_sb !== 8'd0 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_fields: rd %h sb %h rw %b expected 0", out_rd, out_sb, out_reg_write); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    resetn = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    set_beat(1, 0, 32'h11, 0, 5'd1, 1, 2'd0, 3'd2, 8'h01); tick();
    set_beat(1, 0, 32'h22, 0, 5'd2, 1, 2'd0, 3'd2, 8'h02); tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_both: valid %b in_ready %b expected 1 0", out_valid, in_ready); end
    resetn = 1'b0; tick();
    checks++; if (out_valid !== 1'b0 || out_wb_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midstream_reset: valid %b wb %h in_ready %b expected 0 0 0", out_valid, out_wb_data, in_ready); end
    resetn = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midstream_release: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      set_beat(1, 0, k, 0, 5'(k), 1, 2'd0, 3'd2, 8'(k));
      tick();
      checks++; if (out_valid !== 1'b1 || out_wb_data !== 32'(k) || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: valid %b wb %h in_ready %b expected 1 %h 1", k, out_valid, out_wb_data, in_ready, k); end
    end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(1, 0, 32'hA, 0, 5'd10, 1, 2'd0, 3'd2, 8'hA0); tick();
    set_beat(1, 0, 32'hB, 0, 5'd11, 1, 2'd0, 3'd2, 8'hB0); tick();
    set_beat(1, 0, 32'hC, 0, 5'd12, 1, 2'd0, 3'd2, 8'hC0);
    checks++; if (in_ready !== 1'b0 || out_wb_data !== 32'hA) begin
      errors++; $display("FAIL bp_full: in_ready %b wb %h expected 0 a", in_ready, out_wb_data); end
    tick();
    checks++; if (out_wb_data !== 32'hA || out_sb !== 8'hA0) begin
      errors++; $display("FAIL bp_hold: wb %h sb %h expected a a0", out_wb_data, out_sb); end
    out_ready = 1'b1; tick();
    checks++; if (out_wb_data !== 32'hB || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second: wb %h in_ready %b expected b 1", out_wb_data, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_wb_data !== 32'hC || out_rd !== 5'd12) begin
      errors++; $display("FAIL bp_third: wb %h rd %h expected c 0c", out_wb_data, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  offs[5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF8281, 32'h00008281, 32'h82817F80};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(1, 32'h82817F80, {30'h400, offs[i]}, 32'h0, 5'd7, 1, 2'd1, f3s[i], 8'(i));
      tick();
      checks++; if (out_wb_data !== exps[i]) begin
        errors++; $display("FAIL load_%0d: got %h expected %h", i, out_wb_data, exps[i]); end
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_beat(1, 0, 32'h51, 0, 5'd3, 1, 2'd0, 3'd2, 8'h51); tick();
    set_beat(1, 0, 32'h52, 0, 5'd3, 1, 2'd0, 3'd2, 8'h52); tick();
    set_beat(1, 0, 32'h53, 0, 5'd3, 1, 2'd0, 3'd2, 8'h53);
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wb_data !== 32'h0) begin
      errors++; $display("FAIL flush: valid %b in_ready %b wb %h expected 0 1 0", out_valid, in_ready, out_wb_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost_%0d: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_x0();
    out_ready = 1'b1;
    set_beat(1, 0, 32'h55, 32'h104, 5'd0, 1, 2'd2, 3'd2, 8'h00); tick();
    checks++; if (out_wb_data !== 32'h104 || out_reg_write !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL x0: wb %h rw %b valid %b expected 104 0 1", out_wb_data, out_reg_write, out_valid); end
    set_beat(1, 0, 32'h55, 32'h108, 5'd3, 1, 2'd3, 3'd2, 8'h00); tick();
    checks++; if (out_wb_data !== 32'h55 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL rsvd_sel: wb %h rw %b expected 55 1", out_wb_data, out_reg_write); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++; if (out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_valid @%0d: got %b expected %b", c, out_valid, mq.size() > 0); end
      checks++; if (in_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL rand_in_ready @%0d: got %b expected %b", c, in_ready, mq.size() < 2); end
      if (mq.size() > 0) begin
        checks++; if (out_wb_data !== mq[0].wb || out_rd !== mq[0].rd || out_sb !== mq[0].sb ||
                      out_reg_write !== (mq[0].rw && mq[0].rd != 0)) begin
          errors++; $display("FAIL rand_head @%0d: wb %h rd %h sb %h rw %b expected %h %h %h %b", c,
                             out_wb_data, out_rd, out_sb, out_reg_write, mq[0].wb, mq[0].rd, mq[0].sb,
                             mq[0].rw && mq[0].rd != 0); end
      end else begin
        checks++; if (out_wb_data !== 32'h0 || out_reg_write !== 1'b0) begin
          errors++; $display("FAIL rand_idle @%0d: wb %h rw %b expected 0 0", c, out_wb_data, out_reg_write); end
      end
      set_beat($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 31) == 0;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_loads();
    test_flush();
    test_x0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
